// File: rtl/mp64_sram_bport_ctrl.sv
// Port B request controller for mp64_sram_dp.
// Turns valid/ready read/write requests into SRAM strobes. Partial writes
// are done as read-modify-write, since the SRAM port has no byte enables.
// Read data is returned on a single-entry buffered response channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a request; ready when no response is stuck
// RD_ISSUE | read strobe on the SRAM
// RD_DATA  | SRAM read data valid; captured into the response buffer
// WR_ISSUE | full-word write strobe
// RMW_RD   | read strobe for the old row contents
// RMW_WAIT | old data valid; byte merge registered
// RMW_WR   | write strobe with the merged word
module mp64_sram_bport_ctrl #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 64,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              b_ce,
    output logic              b_we,
    output logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_wdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_DATA  = 3'd2,
        WR_ISSUE = 3'd3,
        RMW_RD   = 3'd4,
        RMW_WAIT = 3'd5,
        RMW_WR   = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   merged_q;
    logic [DATA_W-1:0]   merged_d;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                accept;

    // Only take a new request when the response slot is free or draining now,
    // so at most one read result is ever outstanding.
    assign req_ready = (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != IDLE);
    assign b_addr    = addr_q;
    assign b_wdata   = (state_q == RMW_WR) ? merged_q : wdata_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and SRAM strobes.
    always_comb begin
        state_d = state_q;
        b_ce    = 1'b0;
        b_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_we) begin
                        state_d = RD_ISSUE;
                    end else if (req_be == '1) begin
                        state_d = WR_ISSUE;
                    end else if (req_be == '0) begin
                        // Nothing to write: drop the request without touching the SRAM.
                        state_d = IDLE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD_ISSUE: begin
                b_ce    = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                state_d = IDLE;
            end
            WR_ISSUE: begin
                b_ce    = 1'b1;
                b_we    = 1'b1;
                state_d = IDLE;
            end
            RMW_RD: begin
                b_ce    = 1'b1;
                state_d = RMW_WAIT;
            end
            RMW_WAIT: begin
                state_d = RMW_WR;
            end
            RMW_WR: begin
                b_ce    = 1'b1;
                b_we    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-byte merge of new write data over the old row contents.
    always_comb begin
        merged_d = '0;
        for (int i = 0; i < BE_W; i++) begin
            merged_d[i*8 +: 8] = be_q[i] ? wdata_q[i*8 +: 8] : b_rdata[i*8 +: 8];
        end
    end

    // Request latch, merge register and response buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            merged_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (state_q == RMW_WAIT) begin
                merged_q <= merged_d;
            end
            // A capture cannot collide with a stuck response: reads are only
            // accepted once the slot is free or being consumed.
            if (state_q == RD_DATA) begin
                rsp_rdata_q <= b_rdata;
                rsp_valid_q <= 1'b1;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mp64_sram_bport_ctrl.sv
// Testbench for mp64_sram_bport_ctrl with a behavioural registered-read SRAM.
module tb_mp64_sram_bport_ctrl;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              b_ce;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata = '0;
    logic              busy;

    mp64_sram_bport_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .b_ce      (b_ce),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [DATA_W-1:0] mem [int];
    logic [DATA_W-1:0] rsp_d [$];
    int                rsp_c [$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: registered read, write on strobe.
    always @(posedge clk) begin
        if (b_ce) begin
            if (b_we) begin
                mem[int'(b_addr)] = b_wdata;
                wr_cnt++;
            end else begin
                b_rdata <= mem.exists(int'(b_addr)) ? mem[int'(b_addr)] : '0;
                rd_cnt++;
            end
        end
    end

    // Response monitor: records data and the edge number of each handshake.
    always @(posedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_d.push_back(rsp_rdata);
            rsp_c.push_back(cyc + 1);
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; acc = accepting edge number.
    task automatic send(input logic we, input logic [16:0] a, input logic [63:0] d,
                        input logic [7:0] be, output int acc);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        if (!req_ready) chk("accept_timeout", {63'd0, req_ready}, 64'd1);
        tick();
        acc = cyc;
        req_valid = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [16:0] a, input logic [63:0] exp);
        int acc;
        int w;
        rsp_d.delete();
        rsp_c.delete();
        send(1'b0, a, 64'd0, 8'd0, acc);
        w = 0;
        while (rsp_d.size() == 0 && w < 20) begin
            tick();
            w++;
        end
        if (rsp_d.size() == 0) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end else begin
            chk({name, "_data"}, rsp_d[0], exp);
            chk({name, "_lat"}, 64'(rsp_c[0] - acc), 64'd3);
        end
    endtask

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_rdata;
        int          exp_gap;
    } vec_t;

    vec_t vecs [12];
    logic [63:0] exp_d [$];
    int          exp_c [$];

    initial begin
        int acc;
        int last_acc;
        int w;
        int r0;
        int w0;

        vecs[0]  = '{1'b1, 17'h10, 64'hDEADBEEF_01234567, 8'hFF, 64'h0, 0};
        vecs[1]  = '{1'b1, 17'h20, 64'h11111111_11111111, 8'hFF, 64'h0, 2};
        vecs[2]  = '{1'b0, 17'h10, 64'h0, 8'h00, 64'hDEADBEEF_01234567, 2};
        vecs[3]  = '{1'b1, 17'h20, 64'hAAAAAAAA_AAAAAAAA, 8'h0F, 64'h0, 3};
        vecs[4]  = '{1'b0, 17'h20, 64'h0, 8'h00, 64'h11111111_AAAAAAAA, 4};
        vecs[5]  = '{1'b1, 17'h30, 64'h01234567_89ABCDEF, 8'hFF, 64'h0, 3};
        vecs[6]  = '{1'b1, 17'h20, 64'h55555555_55555555, 8'hF0, 64'h0, 2};
        vecs[7]  = '{1'b0, 17'h30, 64'h0, 8'h00, 64'h01234567_89ABCDEF, 4};
        vecs[8]  = '{1'b0, 17'h20, 64'h0, 8'h00, 64'h55555555_AAAAAAAA, 3};
        vecs[9]  = '{1'b1, 17'h40, 64'hCAFEF00D_12345678, 8'h81, 64'h0, 3};
        vecs[10] = '{1'b1, 17'h40, 64'hFFFFFFFF_FFFFFFFF, 8'h00, 64'h0, 4};
        vecs[11] = '{1'b0, 17'h40, 64'h0, 8'h00, 64'hCA000000_00000078, 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state.
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_b_ce", {63'd0, b_ce}, 64'd0);
        chk("rst_b_we", {63'd0, b_we}, 64'd0);
        chk("rst_b_addr", 64'(b_addr), 64'd0);
        chk("rst_b_wdata", b_wdata, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);

        // Back-to-back vector table with acceptance spacing and read scoreboard.
        rsp_d.delete();
        rsp_c.delete();
        last_acc = 0;
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, acc);
            if (i > 0) chk($sformatf("gap_v%0d", i), 64'(acc - last_acc), 64'(vecs[i].exp_gap));
            if (!vecs[i].we) begin
                exp_d.push_back(vecs[i].exp_rdata);
                exp_c.push_back(acc + 3);
            end
            last_acc = acc;
        end
        repeat (6) tick();
        chk("rsp_count", 64'(rsp_d.size()), 64'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && i < rsp_d.size(); i++) begin
            chk($sformatf("rsp_data_%0d", i), rsp_d[i], exp_d[i]);
            chk($sformatf("rsp_edge_%0d", i), 64'(rsp_c[i]), 64'(exp_c[i]));
        end

        // Partial write: exactly one read strobe and one write strobe.
        r0 = rd_cnt;
        w0 = wr_cnt;
        send(1'b1, 17'h50, 64'hABABABAB_ABABABAB, 8'h02, acc);
        repeat (5) tick();
        chk("rmw_rd_strobes", 64'(rd_cnt - r0), 64'd1);
        chk("rmw_wr_strobes", 64'(wr_cnt - w0), 64'd1);
        do_read("rmw_rb", 17'h50, 64'h00000000_0000AB00);

        // Zero byte-enable write: no SRAM access, ready again right away.
        r0 = rd_cnt;
        w0 = wr_cnt;
        send(1'b1, 17'h10, 64'hFFFFFFFF_FFFFFFFF, 8'h00, acc);
        chk("zero_ready", {63'd0, req_ready}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        repeat (3) tick();
        chk("zero_strobes", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);
        do_read("zero_rb", 17'h10, 64'hDEADBEEF_01234567);

        // Response back-pressure with a queued request.
        rsp_ready = 1'b0;
        send(1'b0, 17'h10, 64'd0, 8'd0, acc);
        w = 0;
        while (!rsp_valid && w < 20) begin
            tick();
            w++;
        end
        chk("bp_rise", 64'(cyc - acc), 64'd2);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 17'h30;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("bp_data", rsp_rdata, 64'hDEADBEEF_01234567);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        rsp_d.delete();
        rsp_c.delete();
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        acc = cyc;
        chk("both_rsp_count", 64'(rsp_d.size()), 64'd1);
        if (rsp_d.size() > 0) chk("both_rsp_edge", 64'(rsp_c[0]), 64'(acc));
        chk("both_accept", {63'd0, busy}, 64'd1);
        w = 0;
        while (rsp_d.size() < 2 && w < 20) begin
            tick();
            w++;
        end
        chk("queued_count", 64'(rsp_d.size()), 64'd2);
        if (rsp_d.size() > 1) begin
            chk("queued_data", rsp_d[1], 64'h01234567_89ABCDEF);
            chk("queued_lat", 64'(rsp_c[1] - acc), 64'd3);
        end

        // Reset during RMW_WAIT: no write strobe, row keeps old data.
        send(1'b1, 17'h60, 64'h12345678_9ABCDEF0, 8'hFF, acc);
        tick();
        send(1'b1, 17'h60, 64'hFFFFFFFF_FFFFFFFF, 8'h0F, acc);
        tick();
        chk("rmw_wait_busy", {63'd0, busy}, 64'd1);
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_b_ce", {63'd0, b_ce}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_b_addr", 64'(b_addr), 64'd0);
        tick();
        tick();
        chk("abort_wr_strobes", 64'(wr_cnt - w0), 64'd0);
        rst_n = 1'b1;
        tick();
        do_read("abort_rb", 17'h60, 64'h12345678_9ABCDEF0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
